// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV sequencer for the HI/LO resource.
// One operand bit per cycle over magnitudes, then a single sign-fix cycle before DONE.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic               r_op;
    logic               r_negA;
    logic               r_negB;
    logic               r_divZero;
    logic [WIDTH-1:0]   r_magA;
    logic [WIDTH-1:0]   r_magB;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic               w_bZero;
    logic [WIDTH:0]     w_multSum;
    logic [2*WIDTH-1:0] w_multNext;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_remTrial;
    logic [2*WIDTH-1:0] w_divNext;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    // Magnitudes are unsigned, so the most negative value maps onto itself.
    assign w_magA  = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    assign w_magB  = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
    assign w_bZero = (b_in == '0);

    // Shift-add step: the carry out of the add lands in the top bit after the shift.
    assign w_multSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_magA};
    assign w_multNext = r_magB[r_count]
                        ? {w_multSum, r_acc[WIDTH-1:1]}
                        : {1'b0, r_acc[2*WIDTH-1:1]};

    // Restoring step: dividend bits are fed MSB first from the latched magnitude.
    assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_magA[LAST - r_count]};
    assign w_remTrial = w_remShift - {1'b0, r_magB};
    assign w_divNext  = w_remTrial[WIDTH]
                        ? {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                        : {w_remTrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_product = (r_negA ^ r_negB) ? (~r_acc + 1'b1) : r_acc;
    assign w_quo     = r_acc[WIDTH-1:0];
    assign w_rem     = r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fixHi = w_product[2*WIDTH-1:WIDTH];
        w_fixLo = w_product[WIDTH-1:0];
        if (r_op) begin
            w_fixLo = (r_negA ^ r_negB) ? (~w_quo + 1'b1) : w_quo;
            w_fixHi = r_negA ? (~w_rem + 1'b1) : w_rem;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!op)
                        w_nextState = S_MULT;
                    else if (w_bZero)
                        w_nextState = S_DONE;
                    else
                        w_nextState = S_DIV;
                end
            end
            S_MULT:  if (r_count == LAST) w_nextState = S_FIX;
            S_DIV:   if (r_count == LAST) w_nextState = S_FIX;
            S_FIX:   w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 1'b0;
            r_negA    <= 1'b0;
            r_negB    <= 1'b0;
            r_divZero <= 1'b0;
            r_magA    <= '0;
            r_magB    <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state   <= w_nextState;
            r_divZero <= (r_state == S_IDLE) && start && op && w_bZero;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_negA  <= a_in[WIDTH-1];
                        r_negB  <= b_in[WIDTH-1];
                        r_magA  <= w_magA;
                        r_magB  <= w_magB;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                S_MULT: begin
                    r_acc   <= w_multNext;
                    r_count <= r_count + 1'b1;
                end
                S_DIV: begin
                    r_acc   <= w_divNext;
                    r_count <= r_count + 1'b1;
                end
                S_FIX: begin
                    r_hi <= w_fixHi;
                    r_lo <= w_fixLo;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign div_zero = r_divZero;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the CPU's HI/LO resource. On a one-cycle `start` from the main control unit it runs a signed 32×32 multiply (MULT) or a signed 32/32 divide (DIV). It iterates one bit per cycle over operand magnitudes, applies the sign correction, then loads HI/LO and pulses `done`. The control unit waits on `done` before issuing MFHI/MFLO. Divide-by-zero is reported on `div_zero` so the control unit can raise its exception.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = MULT, 1 = DIV; sampled with `start`.
- `a_in`  in  32  rs operand (A register); sampled with `start`.
- `b_in`  in  32  rt operand (B register); sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE.
- `div_zero`  out  1  one-cycle pulse, coincident with `done`, only for DIV with `b_in == 0`.
- `hi_out`  out  32  HI register.
- `lo_out`  out  32  LO register.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE.
- **IDLE, `start`=1:**
  - Latch |a|, |b|, sign flags and `op`. Clear the 64-bit accumulator and the 5-bit iteration counter.
  - Go to MULT (op=0), DIV (op=1, b≠0), or DONE with `div_zero` set (op=1, b=0).
- **IDLE, `start`=0:** stay.
- **MULT:**
  - Unsigned shift-add, one multiplier bit per cycle, LSB first.
  - If the multiplier bit is 1, add |a| into the upper 33 bits of the product register. Then shift right 1.
  - 32 cycles (counter 0..31). Go to FIX when the counter is 31.
- **DIV:**
  - Restoring division on magnitudes.
  - Each cycle: shift {rem, quo} left 1, trial-subtract |b| from rem. If the result is non-negative, keep it and set quo[0]=1; otherwise restore.
  - 32 cycles. Go to FIX when the counter is 31.
- **FIX (1 cycle):**
  - MULT: if sign(a)≠sign(b), replace the 64-bit product with its two's complement. HI=product[63:32], LO=product[31:0].
  - DIV: LO = quotient, negated if sign(a)≠sign(b). HI = remainder, negated if a<0.
  - Load HI/LO on the FIX→DONE edge.
- **DONE (1 cycle):** `done`=1. Go to IDLE.
- **Magnitudes:**
  - |0x80000000| = 0x80000000, treated as unsigned 32-bit; no overflow flagged.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no exception).
- **Divide by zero:** HI and LO keep their previous values.
- **`start` outside IDLE:** ignored; the in-flight operation is unaffected and no request is queued.
- **`start` in DONE:** ignored. A back-to-back request must be issued on or after the cycle `busy` falls.
- **Operand stability:** `a_in`, `b_in` and `op` may change freely after the sampling edge.

## Timing
- **Reset (`reset`=1 at a rising edge):**
  - Next cycle: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi_out`=0, `lo_out`=0, counter=0.
  - Applies in any state. An operation in progress is abandoned with no `done` pulse.
- **Normal latency (MULT, and DIV with b≠0):**
  - Start sampled at edge E0.
  - Cycles 1–32: MULT/DIV.
  - Cycle 33: FIX.
  - Cycle 34: DONE, with `done`=1 and the new HI/LO already visible on `hi_out`/`lo_out`.
  - Cycle 35: IDLE.
- **DIV by zero:** DONE in cycle 1 after E0, with `done`=`div_zero`=1; IDLE in cycle 2.
- **`busy`:** high from cycle 1 through the DONE cycle inclusive.
- **Outputs:** all registered; no combinational path from inputs to outputs.
- **HI/LO hold:** HI/LO change only on the FIX→DONE edge or on reset.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `start`=1 → `busy`=0, `done`=0, `hi_out`=`lo_out`=0; no operation starts.
- **MULT 7 × 0xFFFFFFFD (−3):** `done` exactly 34 cycles after start, `hi_out`=0xFFFFFFFF, `lo_out`=0xFFFFFFEB, `div_zero`=0, `busy` high for 34 cycles.
- **MULT 0x80000000 × 0x80000000:** `hi_out`=0x40000000, `lo_out`=0x00000000. Then MULT 0xFFFFFFFF × 0xFFFFFFFF → `hi_out`=0, `lo_out`=1.
- **DIV 0xFFFFFFF9 (−7) / 2:** `lo_out`=0xFFFFFFFD, `hi_out`=0xFFFFFFFF at cycle 34. Then DIV 0x80000000 / 0xFFFFFFFF → `lo_out`=0x80000000, `hi_out`=0.
- **DIV 5 / 0 after a prior result HI=0x11, LO=0x22:**
  - `done`=`div_zero`=1 one cycle after start.
  - `hi_out`=0x11, `lo_out`=0x22 unchanged.
  - `busy` high for exactly 1 cycle.
- **Ignored `start` and mid-operation reset:**
  - Pulse `start` with new operands at cycle 10 of a MULT → the original result is unaffected and there is exactly one `done`.
  - Assert `reset` at cycle 20 of a DIV → IDLE, outputs zero on the next cycle, no `done`.
  - A new MULT 3×4 started after the reset gives `lo_out`=12.
